// File: rtl/io_port_bridge_pkg.sv
// Shared constants for the core I/O bridge and its FIFOs.
package io_port_bridge_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with combinational head read; dout is forced to 0 while empty.
module io_fifo
    import io_port_bridge_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; the empty gate on dout hides stale words after reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_port_bridge.sv
// Core I/O bridge: input FIFO feeds read_in, output FIFO drains write_out, sticky error flags.
module io_port_bridge
    import io_port_bridge_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] ext_in_data,
    input  logic             ext_in_valid,
    output logic             ext_in_ready,
    output logic [WIDTH-1:0] read_in,
    output logic             in_avail,
    input  logic             cpu_rd,
    input  logic [WIDTH-1:0] write_out,
    input  logic             cpu_wr,
    output logic             cpu_stall,
    output logic [WIDTH-1:0] ext_out_data,
    output logic             ext_out_valid,
    input  logic             ext_out_ready,
    output logic [PTR_W:0]   in_count,
    output logic [PTR_W:0]   out_count,
    output logic             underflow,
    output logic             overflow
);

    logic in_full;
    logic in_empty;
    logic out_full;
    logic out_empty;
    logic underflow_q;
    logic overflow_q;

    assign ext_in_ready  = !in_full;
    assign in_avail      = !in_empty;
    assign cpu_stall     = out_full;
    assign ext_out_valid = !out_empty;
    assign underflow     = underflow_q;
    assign overflow      = overflow_q;

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_in_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (ext_in_valid && ext_in_ready),
        .pop   (cpu_rd && in_avail),
        .din   (ext_in_data),
        .dout  (read_in),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    // A core write while stalled is dropped and only recorded in overflow.
    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_out_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (cpu_wr && !cpu_stall),
        .pop   (ext_out_valid && ext_out_ready),
        .din   (write_out),
        .dout  (ext_out_data),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (cpu_rd && in_empty) underflow_q <= 1'b1;
            if (cpu_wr && out_full) overflow_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Scoreboard bench for io_port_bridge: stimulus queues expected words, a monitor checks each pop.
module tb_io_port_bridge;

    logic        clock;
    logic        rst;
    logic [15:0] ext_in_data;
    logic        ext_in_valid;
    logic        ext_in_ready;
    logic [15:0] read_in;
    logic        in_avail;
    logic        cpu_rd;
    logic [15:0] write_out;
    logic        cpu_wr;
    logic        cpu_stall;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready;
    logic [2:0]  in_count;
    logic [2:0]  out_count;
    logic        underflow;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] in_q[$];
    logic [15:0] out_q[$];
    logic [15:0] exp_in;
    logic [15:0] exp_out;

    io_port_bridge dut (
        .clock         (clock),
        .rst           (rst),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .read_in       (read_in),
        .in_avail      (in_avail),
        .cpu_rd        (cpu_rd),
        .write_out     (write_out),
        .cpu_wr        (cpu_wr),
        .cpu_stall     (cpu_stall),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_count      (in_count),
        .out_count     (out_count),
        .underflow     (underflow),
        .overflow      (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: whenever a word will be consumed at the next edge, compare it to the scoreboard.
    always @(negedge clock) begin
        if (!rst) begin
            if (cpu_rd && in_avail) begin
                if (in_q.size() == 0) begin
                    check("read_in_unexpected", {16'h0, read_in}, 32'hFFFF_FFFF);
                end else begin
                    exp_in = in_q.pop_front();
                    check("read_in", {16'h0, read_in}, {16'h0, exp_in});
                end
            end
            if (ext_out_valid && ext_out_ready) begin
                if (out_q.size() == 0) begin
                    check("ext_out_unexpected", {16'h0, ext_out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_out = out_q.pop_front();
                    check("ext_out_data", {16'h0, ext_out_data}, {16'h0, exp_out});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] in_words [3];
        in_words[0] = 16'h0011;
        in_words[1] = 16'h0022;
        in_words[2] = 16'h0033;

        rst = 1'b1;
        ext_in_data = '0;
        ext_in_valid = 1'b0;
        cpu_rd = 1'b0;
        write_out = '0;
        cpu_wr = 1'b0;
        ext_out_ready = 1'b0;
        #12 rst = 1'b0;
        tick();

        // Reset then idle.
        check("rst_ext_in_ready", ext_in_ready, 1);
        check("rst_in_avail", in_avail, 0);
        check("rst_ext_out_valid", ext_out_valid, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_in_count", in_count, 0);
        check("rst_out_count", out_count, 0);
        check("rst_underflow", underflow, 0);
        check("rst_overflow", overflow, 0);
        check("rst_read_in", read_in, 0);
        check("rst_ext_out_data", ext_out_data, 0);

        // Three pushes then three pops, in order.
        for (int i = 0; i < 3; i++) begin
            ext_in_data = in_words[i];
            ext_in_valid = 1'b1;
            in_q.push_back(in_words[i]);
            tick();
            if (i == 0) check("read_in_after_first_push", read_in, 16'h0011);
        end
        ext_in_valid = 1'b0;
        check("in_count_3", in_count, 3);
        for (int i = 0; i < 3; i++) begin
            cpu_rd = 1'b1;
            tick();
            check("in_count_pop", in_count, 2 - i);
        end
        cpu_rd = 1'b0;
        check("in_avail_drained", in_avail, 0);
        check("read_in_drained", read_in, 0);

        // Five pushes into a 4-deep FIFO: the fifth waits for one pop.
        for (int i = 0; i < 4; i++) begin
            ext_in_data = 16'h00A0 + 16'(i);
            ext_in_valid = 1'b1;
            in_q.push_back(16'h00A0 + 16'(i));
            tick();
        end
        check("in_full_ready", ext_in_ready, 0);
        check("in_full_count", in_count, 4);
        ext_in_data = 16'h00A4;
        in_q.push_back(16'h00A4);
        tick();
        tick();
        check("in_held_count", in_count, 4);
        check("in_held_ready", ext_in_ready, 0);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        check("in_after_pop_count", in_count, 3);
        check("in_after_pop_ready", ext_in_ready, 1);
        tick();
        ext_in_valid = 1'b0;
        check("in_fifth_accepted", in_count, 4);
        for (int i = 0; i < 4; i++) begin
            cpu_rd = 1'b1;
            tick();
        end
        cpu_rd = 1'b0;
        check("in_drain_count", in_count, 0);

        // Fill output FIFO, overflow with a fifth write, then drain.
        ext_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_out = 16'h1000 + 16'(i);
            cpu_wr = 1'b1;
            out_q.push_back(16'h1000 + 16'(i));
            tick();
        end
        cpu_wr = 1'b0;
        check("out_full_stall", cpu_stall, 1);
        check("out_full_count", out_count, 4);
        check("out_no_overflow_yet", overflow, 0);
        check("out_head", ext_out_data, 16'h1000);
        write_out = 16'h1004;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        check("out_overflow", overflow, 1);
        check("out_count_after_drop", out_count, 4);
        ext_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ext_out_ready = 1'b0;
        check("out_drained_count", out_count, 0);
        check("out_drained_valid", ext_out_valid, 0);
        check("out_scoreboard_empty", out_q.size(), 0);

        // Full FIFO with simultaneous write and pop: pop wins, write dropped.
        rst = 1'b1;
        #2 rst = 1'b0;
        check("rst2_overflow", overflow, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            write_out = 16'h2000 + 16'(i);
            cpu_wr = 1'b1;
            out_q.push_back(16'h2000 + 16'(i));
            tick();
        end
        write_out = 16'h2004;
        ext_out_ready = 1'b1;
        tick();
        cpu_wr = 1'b0;
        ext_out_ready = 1'b0;
        check("simul_out_count", out_count, 3);
        check("simul_overflow", overflow, 1);
        check("simul_head", ext_out_data, 16'h2001);
        ext_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ext_out_ready = 1'b0;
        check("simul_drained", out_count, 0);

        // Underflow is sticky.
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        check("underflow_set", underflow, 1);
        check("underflow_read_in", read_in, 0);
        check("underflow_in_count", in_count, 0);
        tick();
        tick();
        check("underflow_sticky", underflow, 1);

        // Asynchronous reset mid-burst with words queued in both FIFOs.
        ext_in_data = 16'h0055;
        ext_in_valid = 1'b1;
        tick();
        ext_in_data = 16'h0066;
        tick();
        ext_in_valid = 1'b0;
        write_out = 16'h3000;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        check("pre_rst_in_count", in_count, 2);
        check("pre_rst_out_count", out_count, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_in_count", in_count, 0);
        check("async_rst_out_count", out_count, 0);
        check("async_rst_underflow", underflow, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_in_avail", in_avail, 0);
        check("async_rst_out_valid", ext_out_valid, 0);
        check("async_rst_read_in", read_in, 0);
        in_q.delete();
        out_q.delete();
        @(negedge clock);
        rst = 1'b0;
        tick();
        check("post_rst_ready", ext_in_ready, 1);
        check("in_scoreboard_empty", in_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
